uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Sits directly downstream of the UART receiver and upstream of its transmitter. Consumes received bytes, packs every four into a 32-bit instruction word (MSB first), and writes it to instruction memory at an auto-incrementing word address. After each write it sends a one-byte reply through the UART transmitter. Loading ends on the halt word or when memory is full.

## Interface
- NB_DATA, 8, UART byte width
- NB_WORD, 32, instruction word width; must equal 4*NB_DATA
- NB_ADDR, 8, word-address width (memory depth 2**NB_ADDR words)
- HALT_WORD, 32'hFFFF_FFFF, end-of-program word
- ACK_BYTE / DONE_BYTE / NAK_BYTE, 8'hAA / 8'h55 / 8'hEE, reply codes

- i_clock  in  1  single clock; all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  byte from UART receiver, valid with i_rx_done_tick
- i_rx_done_tick  in  1  one-cycle pulse, byte available
- i_tx_done_tick  in  1  one-cycle pulse, transmitter finished current byte
- i_rearm  in  1  level/pulse; leaves DONE and restarts loading at address 0
- o_tx_data  out  NB_DATA  reply byte to transmitter; held stable from o_tx_start until i_tx_done_tick
- o_tx_start  out  1  one-cycle pulse starting transmission
- o_mem_wr_en  out  1  one-cycle write strobe
- o_mem_addr  out  NB_ADDR  word address of current write
- o_mem_data  out  NB_WORD  assembled word
- o_load_done  out  1  high while in DONE
- o_error  out  1  high in DONE if ended by memory full without halt

## Operation
- States: RECV, WRITE, REPLY, WAIT_TX, DONE. Reset state RECV.
- RECV: each i_rx_done_tick shifts i_rx_data into the word register (first byte -> bits [31:24]); the byte counter counts 0..3. The 4th byte moves the FSM to WRITE, and the counter returns to 0.
- WRITE (1 cycle): o_mem_wr_en=1 with the current addr/data. Reply selection:
  - word==HALT_WORD: DONE_BYTE
  - else addr==2**NB_ADDR-1: NAK_BYTE, error flag set
  - else: ACK_BYTE
  The address increments only for ACK; it never wraps. Next state is REPLY.
- REPLY (1 cycle): o_tx_start=1, o_tx_data=selected reply; then WAIT_TX.
- WAIT_TX: hold until i_tx_done_tick. Then go to DONE if the reply was DONE_BYTE or NAK_BYTE, else RECV.
- DONE: o_load_done=1. All rx bytes are ignored. i_rearm moves to RECV, with addr=0, byte counter=0, o_error=0.
- Rx bytes arriving in WRITE/REPLY/WAIT_TX/DONE are dropped. The host must wait for the reply before sending the next word.
- i_rearm outside DONE: ignored.

## Timing
- Reset (async assert, sync release internally not required): all outputs 0, addr=0, byte counter=0, word register=0, state RECV. Partial words are discarded.
- 4th byte tick at cycle t: o_mem_wr_en high at t+1, o_tx_start high at t+2. WAIT_TX begins at t+3.
- i_tx_done_tick at cycle u: FSM is in RECV/DONE at u+1. A tick at u+1 is captured.
- i_tx_done_tick outside WAIT_TX: ignored.
- Simultaneous i_rx_done_tick and i_tx_done_tick in WAIT_TX: the byte is dropped and the state advances.
- o_mem_addr/o_mem_data are registered and stable during the o_mem_wr_en cycle.

## Structure
- Shared package `uart_loader_pkg` holds:
  - state enumeration
  - ACK/DONE/NAK byte constants
  - HALT_WORD default
- Natural sub-module `uart_byte_packer`: shift register, 2-bit byte counter, and word_valid pulse, with a clear input driven by rearm.
- The top contains the FSM, address counter and reply mux.

## Test plan
- Send 11 22 33 44 -> one write addr 0 data 32'h11223344; o_tx_start with 8'hAA two cycles after the 4th tick; addr becomes 1.
- Send three words, then FF FF FF FF -> writes at 0..3, the last being the halt word; replies AA AA AA 55; o_load_done=1, o_error=0.
- NB_ADDR=2, send four non-halt words -> the 4th write is at addr 3 with reply EE, o_error=1, o_load_done=1, and no address wrap.
- In DONE, send bytes (no writes), then pulse i_rearm, then send 01 02 03 04 -> write addr 0 data 32'h01020304, o_error cleared.
- Send 2 bytes of a word, assert i_reset low mid-word, release, send AA BB CC DD -> a single write of 32'hAABBCCDD at addr 0.
- Send a byte while in WAIT_TX (same cycle as i_tx_done_tick and later) -> the byte is dropped; the next four bytes form the next word exactly.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM states, reply codes
// and the default end-of-program word.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      ST_RECV    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_REPLY   = 3'd2,
      ST_WAIT_TX = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int          NB_DATA_DEFAULT   = 8;
   localparam int          NB_WORD_DEFAULT   = 32;
   localparam int          NB_ADDR_DEFAULT   = 8;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   localparam logic [7:0]  ACK_CODE  = 8'hAA;
   localparam logic [7:0]  DONE_CODE = 8'h55;
   localparam logic [7:0]  NAK_CODE  = 8'hEE;

endpackage

// File: rtl/uart_byte_packer.sv
// Packs four received UART bytes into one instruction word, first byte in
// the most significant position, and flags the byte that completes a word.
module uart_byte_packer #(
   parameter int NB_DATA = 8,
   parameter int NB_WORD = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_enable,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done_tick,
   output logic [NB_WORD-1:0] o_word,
   output logic               o_word_valid
);

   logic [NB_WORD-1:0] r_word;
   logic [1:0]         r_count;
   logic               w_accept;

   assign w_accept     = i_enable && i_rx_done_tick;
   assign o_word_valid = w_accept && (r_count == 2'd3);
   assign o_word       = r_word;

   // Shift accepted bytes in from the bottom; the 2-bit counter wraps to 0 on the 4th byte
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_word  <= '0;
         r_count <= 2'd0;
      end else if (i_clear) begin
         r_word  <= '0;
         r_count <= 2'd0;
      end else if (w_accept) begin
         r_word  <= {r_word[NB_WORD-NB_DATA-1:0], i_rx_data};
         r_count <= r_count + 2'd1;
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: assembles received bytes into instruction words,
// writes them to instruction memory at an auto-incrementing address and
// answers every write with a one-byte reply through the UART transmitter.
module uart_program_loader
   import uart_loader_pkg::*;
#(
   parameter int                 NB_DATA   = NB_DATA_DEFAULT,
   parameter int                 NB_WORD   = NB_WORD_DEFAULT,
   parameter int                 NB_ADDR   = NB_ADDR_DEFAULT,
   parameter logic [NB_WORD-1:0] HALT_WORD = HALT_WORD_DEFAULT,
   parameter logic [NB_DATA-1:0] ACK_BYTE  = ACK_CODE,
   parameter logic [NB_DATA-1:0] DONE_BYTE = DONE_CODE,
   parameter logic [NB_DATA-1:0] NAK_BYTE  = NAK_CODE
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done_tick,
   input  logic               i_tx_done_tick,
   input  logic               i_rearm,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_mem_wr_en,
   output logic [NB_ADDR-1:0] o_mem_addr,
   output logic [NB_WORD-1:0] o_mem_data,
   output logic               o_load_done,
   output logic               o_error
);

   state_t             r_state;
   state_t             w_next_state;
   logic [NB_ADDR-1:0] r_addr;
   logic [NB_DATA-1:0] r_reply;
   logic [NB_DATA-1:0] w_reply;
   logic               r_end_load;
   logic               r_error;
   logic [NB_WORD-1:0] w_word;
   logic               w_word_valid;
   logic               w_rearm;
   logic               w_recv;
   logic               w_is_halt;
   logic               w_last_addr;

   assign w_recv      = (r_state == ST_RECV);
   assign w_rearm     = (r_state == ST_DONE) && i_rearm;
   assign w_is_halt   = (w_word == HALT_WORD);
   assign w_last_addr = (r_addr == {NB_ADDR{1'b1}});

   uart_byte_packer #(
      .NB_DATA (NB_DATA),
      .NB_WORD (NB_WORD)
   ) u_packer (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_clear        (w_rearm),
      .i_enable       (w_recv),
      .i_rx_data      (i_rx_data),
      .i_rx_done_tick (i_rx_done_tick),
      .o_word         (w_word),
      .o_word_valid   (w_word_valid)
   );

   // Reply choice: the halt word always ends cleanly, even when it lands on the last address
   always_comb begin
      w_reply = ACK_BYTE;
      if (w_is_halt) begin
         w_reply = DONE_BYTE;
      end else if (w_last_addr) begin
         w_reply = NAK_BYTE;
      end
   end

   // FSM state register
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_RECV;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic; rx bytes outside RECV never reach the packer
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_RECV: begin
            if (w_word_valid) begin
               w_next_state = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_next_state = ST_REPLY;
         end
         ST_REPLY: begin
            w_next_state = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (i_tx_done_tick) begin
               w_next_state = r_end_load ? ST_DONE : ST_RECV;
            end
         end
         ST_DONE: begin
            if (i_rearm) begin
               w_next_state = ST_RECV;
            end
         end
         default: begin
            w_next_state = ST_RECV;
         end
      endcase
   end

   // Address, latched reply and error flag; the address only advances on ACK so it never wraps
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_addr     <= '0;
         r_reply    <= '0;
         r_end_load <= 1'b0;
         r_error    <= 1'b0;
      end else if (w_rearm) begin
         r_addr     <= '0;
         r_end_load <= 1'b0;
         r_error    <= 1'b0;
      end else if (r_state == ST_WRITE) begin
         r_reply    <= w_reply;
         r_end_load <= w_is_halt || w_last_addr;
         if (!w_is_halt && !w_last_addr) begin
            r_addr <= r_addr + NB_ADDR'(1);
         end
         if (!w_is_halt && w_last_addr) begin
            r_error <= 1'b1;
         end
      end
   end

   assign o_mem_wr_en = (r_state == ST_WRITE);
   assign o_mem_addr  = r_addr;
   assign o_mem_data  = w_word;
   assign o_tx_start  = (r_state == ST_REPLY);
   assign o_tx_data   = r_reply;
   assign o_load_done = (r_state == ST_DONE);
   assign o_error     = r_error;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader with a 4-word memory, so the
// memory-full path is reachable quickly. Expected writes and replies come
// from a word-level model of the loading protocol.
module tb_uart_program_loader;

   localparam int          NB_ADDR  = 2;
   localparam int          MAX_ADDR = 3;
   localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
   localparam logic [7:0]  ACK      = 8'hAA;
   localparam logic [7:0]  DONE     = 8'h55;
   localparam logic [7:0]  NAK      = 8'hEE;

   logic               clock   = 1'b0;
   logic               resetN  = 1'b1;
   logic [7:0]         rxData  = 8'h00;
   logic               rxTick  = 1'b0;
   logic               txTick  = 1'b0;
   logic               rearm   = 1'b0;
   logic [7:0]         txData;
   logic               txStart;
   logic               wrEn;
   logic [NB_ADDR-1:0] memAddr;
   logic [31:0]        memData;
   logic               loadDone;
   logic               error;

   int checks  = 0;
   int errors  = 0;
   int wrCount = 0;

   int mAddr   = 0;
   int mWrites = 0;
   bit mError  = 1'b0;
   bit mDone   = 1'b0;

   uart_program_loader #(
      .NB_ADDR (NB_ADDR)
   ) dut (
      .i_clock        (clock),
      .i_reset        (resetN),
      .i_rx_data      (rxData),
      .i_rx_done_tick (rxTick),
      .i_tx_done_tick (txTick),
      .i_rearm        (rearm),
      .o_tx_data      (txData),
      .o_tx_start     (txStart),
      .o_mem_wr_en    (wrEn),
      .o_mem_addr     (memAddr),
      .o_mem_data     (memData),
      .o_load_done    (loadDone),
      .o_error        (error)
   );

   always #5 clock = ~clock;

   // Count every write strobe seen away from the active edge
   always @(negedge clock) begin
      if (wrEn === 1'b1) wrCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic driveByte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clock);
      rxData = b;
      rxTick = 1'b1;
      @(negedge clock);
      rxTick = 1'b0;
   endtask

   function automatic logic [31:0] randomWord();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      return w;
   endfunction

   // Sends one word and checks the write cycle, the reply and the end-of-reply state
   task automatic applyStimulus(input logic [31:0] word, input bit dropTest);
      logic [7:0] expReply;
      int         expAddr;
      expAddr = mAddr;
      if (word == HALT) expReply = DONE;
      else if (mAddr == MAX_ADDR) expReply = NAK;
      else expReply = ACK;
      for (int i = 0; i < 4; i++) driveByte(word[31-8*i -: 8], $urandom_range(0, 2));
      checkOutput("wr_en", {31'd0, wrEn}, 32'd1);
      checkOutput("mem_addr", {30'd0, memAddr}, expAddr);
      checkOutput("mem_data", memData, word);
      checkOutput("tx_start_early", {31'd0, txStart}, 32'd0);
      @(negedge clock);
      checkOutput("tx_start", {31'd0, txStart}, 32'd1);
      checkOutput("tx_data", {24'd0, txData}, {24'd0, expReply});
      checkOutput("wr_en_pulse", {31'd0, wrEn}, 32'd0);
      mWrites++;
      if (expReply == ACK) mAddr++;
      if (expReply == NAK) mError = 1'b1;
      @(negedge clock);
      checkOutput("tx_start_pulse", {31'd0, txStart}, 32'd0);
      checkOutput("write_count", wrCount, mWrites);
      checkOutput("addr_after", {30'd0, memAddr}, mAddr);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      checkOutput("tx_data_hold", {24'd0, txData}, {24'd0, expReply});
      if (dropTest) begin
         driveByte(8'h5A, 0);
         rxData = 8'hC3;
         rxTick = 1'b1;
      end
      txTick = 1'b1;
      @(negedge clock);
      txTick = 1'b0;
      rxTick = 1'b0;
      mDone = (expReply != ACK);
      checkOutput("load_done", {31'd0, loadDone}, {31'd0, mDone});
      checkOutput("error", {31'd0, error}, {31'd0, mError});
   endtask

   task automatic doReset();
      rxTick = 1'b0;
      txTick = 1'b0;
      resetN = 1'b0;
      #1;
      checkOutput("reset_tx_data", {24'd0, txData}, 32'd0);
      checkOutput("reset_tx_start", {31'd0, txStart}, 32'd0);
      checkOutput("reset_wr_en", {31'd0, wrEn}, 32'd0);
      checkOutput("reset_addr", {30'd0, memAddr}, 32'd0);
      checkOutput("reset_data", memData, 32'd0);
      checkOutput("reset_done", {31'd0, loadDone}, 32'd0);
      checkOutput("reset_error", {31'd0, error}, 32'd0);
      @(negedge clock);
      resetN = 1'b1;
      mAddr  = 0;
      mError = 1'b0;
      mDone  = 1'b0;
   endtask

   task automatic rearmPulse();
      rearm = 1'b1;
      @(negedge clock);
      rearm = 1'b0;
      mAddr  = 0;
      mError = 1'b0;
      mDone  = 1'b0;
      checkOutput("rearm_done", {31'd0, loadDone}, 32'd0);
      checkOutput("rearm_error", {31'd0, error}, 32'd0);
      checkOutput("rearm_addr", {30'd0, memAddr}, 32'd0);
   endtask

   initial begin
      int n;
      #1;
      @(negedge clock);
      doReset();

      // First word lands at address 0 and bumps the address
      applyStimulus(32'h1122_3344, 1'b0);
      checkOutput("first_addr_next", {30'd0, memAddr}, 32'd1);

      // Rearm and a stray tx tick outside DONE/WAIT_TX change nothing
      rearm = 1'b1;
      txTick = 1'b1;
      @(negedge clock);
      rearm = 1'b0;
      txTick = 1'b0;
      checkOutput("rearm_ignored", {30'd0, memAddr}, mAddr);
      checkOutput("rearm_ignored_done", {31'd0, loadDone}, 32'd0);

      // Three words then the halt word, which falls on the last address
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(randomWord(), 1'b0);
      applyStimulus(HALT, 1'b0);
      checkOutput("halt_done", {31'd0, loadDone}, 32'd1);
      checkOutput("halt_no_error", {31'd0, error}, 32'd0);

      // Bytes in DONE are dropped; rearm restarts at address 0
      for (int i = 0; i < 6; i++) driveByte(8'($urandom), 0);
      repeat (3) @(negedge clock);
      checkOutput("done_no_write", wrCount, mWrites);
      checkOutput("done_hold", {31'd0, loadDone}, 32'd1);
      rearmPulse();
      applyStimulus(32'h0102_0304, 1'b0);

      // Fill memory with non-halt words until the NAK
      n = 0;
      while (!mDone && n < 8) begin
         applyStimulus(randomWord(), 1'b0);
         n++;
      end
      checkOutput("full_error", {31'd0, error}, 32'd1);
      checkOutput("full_done", {31'd0, loadDone}, 32'd1);
      checkOutput("full_no_wrap", {30'd0, memAddr}, MAX_ADDR);

      // Reset in the middle of a word discards the partial bytes
      rearmPulse();
      driveByte(8'h12, 0);
      driveByte(8'h34, 1);
      doReset();
      applyStimulus(32'hAABB_CCDD, 1'b0);

      // Bytes during WAIT_TX, including one alongside the tx tick, are dropped
      applyStimulus(randomWord(), 1'b1);
      applyStimulus(32'hCAFE_F00D, 1'b0);

      // Randomized loading sessions with occasional halt words
      for (int round = 0; round < 4; round++) begin
         if (mDone) rearmPulse();
         else doReset();
         n = 0;
         while (!mDone && n < 8) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            applyStimulus(($urandom_range(0, 3) == 0) ? HALT : randomWord(), 1'b0);
            n++;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
